// File: rtl/duck_flight_ctrl.sv
// Duck sprite flight controller: per-frame motion, animation and life cycle
// (IDLE -> FLY -> HIT -> FALL -> IDLE, or FLY -> escape -> IDLE).
module duck_flight_ctrl #(
  parameter int unsigned XMIN       = 0,
  parameter int unsigned XMAX       = 736,
  parameter int unsigned YSTART     = 480,
  parameter int unsigned YTOP       = 0,
  parameter int unsigned YGROUND    = 480,
  parameter int unsigned SPEED_X    = 2,
  parameter int unsigned SPEED_Y    = 1,
  parameter int unsigned FALL_SPEED = 4,
  parameter int unsigned ANIM_DIV   = 8,
  parameter int unsigned HIT_TICKS  = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        start,
  input  logic [11:0] start_x,
  input  logic        start_dir,
  input  logic        hit,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [1:0]  frame_sel,
  output logic        invert,
  output logic        active,
  output logic        escaped,
  output logic        landed
);

  localparam int unsigned PW     = 12;
  localparam int unsigned AW     = PW + 1;
  localparam int unsigned ANIM_W = (ANIM_DIV > 2) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned HOLD_W = (HIT_TICKS > 2) ? $clog2(HIT_TICKS) : 1;

  // Limits and steps widened to the 13-bit arithmetic width so sums never wrap
  localparam logic [AW-1:0] XMIN_W    = AW'(XMIN);
  localparam logic [AW-1:0] XMAX_W    = AW'(XMAX);
  localparam logic [AW-1:0] YTOP_W    = AW'(YTOP);
  localparam logic [AW-1:0] YGROUND_W = AW'(YGROUND);
  localparam logic [AW-1:0] SPX_W     = AW'(SPEED_X);
  localparam logic [AW-1:0] SPY_W     = AW'(SPEED_Y);
  localparam logic [AW-1:0] FALL_W    = AW'(FALL_SPEED);

  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);
  localparam logic [ANIM_W-1:0] ANIM_ONE  = ANIM_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HIT_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_HIT  = 2'd2,
    S_FALL = 2'd3
  } state_t;

  state_t              state;
  logic                vsync_d;
  logic [ANIM_W-1:0]   anim_cnt;
  logic [HOLD_W-1:0]   hold_cnt;

  logic                tick;
  logic [AW-1:0]       x_ext;
  logic [AW-1:0]       y_ext;
  logic [AW-1:0]       x_right;
  logic [AW-1:0]       x_left;
  logic [AW-1:0]       x_left_lim;
  logic [AW-1:0]       y_up;
  logic [AW-1:0]       y_up_lim;
  logic [AW-1:0]       y_fall;

  // One-cycle frame tick on the rising edge of vsync
  assign tick = vsync & ~vsync_d;

  // Candidate positions and limits, all in 13 bits
  assign x_ext      = {1'b0, xpos};
  assign y_ext      = {1'b0, ypos};
  assign x_right    = x_ext + SPX_W;
  assign x_left     = x_ext - SPX_W;
  assign x_left_lim = XMIN_W + SPX_W;
  assign y_up       = y_ext - SPY_W;
  assign y_up_lim   = YTOP_W + SPY_W;
  assign y_fall     = y_ext + FALL_W;

  // Life-cycle FSM with registered sprite outputs and event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vsync_d   <= 1'b0;
      anim_cnt  <= '0;
      hold_cnt  <= '0;
      xpos      <= PW'(XMIN);
      ypos      <= PW'(YSTART);
      frame_sel <= 2'd0;
      invert    <= 1'b0;
      active    <= 1'b0;
      escaped   <= 1'b0;
      landed    <= 1'b0;
    end else begin
      vsync_d <= vsync;
      escaped <= 1'b0;
      landed  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FLY;
            xpos      <= start_x;
            ypos      <= PW'(YSTART);
            invert    <= start_dir;
            frame_sel <= 2'd0;
            anim_cnt  <= '0;
            active    <= 1'b1;
          end
        end

        S_FLY: begin
          // A shot takes priority over any movement due on the same cycle
          if (hit) begin
            state     <= S_HIT;
            frame_sel <= 2'd3;
            hold_cnt  <= '0;
          end else if (tick) begin
            if (!invert) begin
              if (x_right >= XMAX_W) begin
                xpos   <= PW'(XMAX);
                invert <= 1'b1;
              end else begin
                xpos   <= x_right[PW-1:0];
              end
            end else begin
              if (x_ext <= x_left_lim) begin
                xpos   <= PW'(XMIN);
                invert <= 1'b0;
              end else begin
                xpos   <= x_left[PW-1:0];
              end
            end

            if (y_ext <= y_up_lim) begin
              ypos      <= PW'(YTOP);
              escaped   <= 1'b1;
              state     <= S_IDLE;
              active    <= 1'b0;
              frame_sel <= 2'd0;
            end else begin
              ypos <= y_up[PW-1:0];
              if (anim_cnt == ANIM_LAST) begin
                anim_cnt  <= '0;
                frame_sel <= (frame_sel == 2'd2) ? 2'd0 : frame_sel + 2'd1;
              end else begin
                anim_cnt  <= anim_cnt + ANIM_ONE;
              end
            end
          end
        end

        S_HIT: begin
          // Hold the hit pose for a fixed number of frames
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state <= S_FALL;
            end else begin
              hold_cnt <= hold_cnt + HOLD_ONE;
            end
          end
        end

        S_FALL: begin
          if (tick) begin
            if (y_fall >= YGROUND_W) begin
              ypos      <= PW'(YGROUND);
              landed    <= 1'b1;
              state     <= S_IDLE;
              active    <= 1'b0;
              frame_sel <= 2'd0;
            end else begin
              ypos <= y_fall[PW-1:0];
            end
          end
        end

        default: begin
          state  <= S_IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Scoreboard bench for duck_flight_ctrl: a behavioural duck model pushes the
// expected sprite state per frame, popped and compared after the DUT updates.
module tb_duck_flight_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic        start;
  logic [11:0] start_x;
  logic        start_dir;
  logic        hit;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [1:0]  frame_sel;
  logic        invert;
  logic        active;
  logic        escaped;
  logic        landed;

  duck_flight_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .start     (start),
    .start_x   (start_x),
    .start_dir (start_dir),
    .hit       (hit),
    .xpos      (xpos),
    .ypos      (ypos),
    .frame_sel (frame_sel),
    .invert    (invert),
    .active    (active),
    .escaped   (escaped),
    .landed    (landed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  f;
    logic        inv;
    logic        act;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int esc_seen  = 0;
  int land_seen = 0;
  int both_seen = 0;

  // Reference duck: 0 idle, 1 fly, 2 hit, 3 fall
  int m_st, m_x, m_y, m_f, m_inv, m_act, m_anim, m_hold;

  // Count event pulses once per clock cycle
  always @(negedge clk) begin
    if (escaped === 1'b1) esc_seen++;
    if (landed === 1'b1) land_seen++;
    if (escaped === 1'b1 && landed === 1'b1) both_seen++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic exp_t snap();
    exp_t e;
    e.x = 12'(m_x); e.y = 12'(m_y); e.f = 2'(m_f);
    e.inv = 1'(m_inv); e.act = 1'(m_act);
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t e;
    e.x = xpos; e.y = ypos; e.f = frame_sel; e.inv = invert; e.act = active;
    return e;
  endfunction

  function automatic exp_t mk(input int x, input int y, input int f, input int inv, input int act);
    exp_t e;
    e.x = 12'(x); e.y = 12'(y); e.f = 2'(f); e.inv = 1'(inv); e.act = 1'(act);
    return e;
  endfunction

  task automatic model_reset();
    m_st = 0; m_x = 0; m_y = 480; m_f = 0; m_inv = 0; m_act = 0; m_anim = 0; m_hold = 0;
  endtask

  task automatic model_tick();
    case (m_st)
      1: begin
        if (m_inv == 0) begin
          if (m_x + 2 >= 736) begin m_x = 736; m_inv = 1; end
          else m_x = m_x + 2;
        end else begin
          if (m_x <= 2) begin m_x = 0; m_inv = 0; end
          else m_x = m_x - 2;
        end
        if (m_y <= 1) begin
          m_y = 0; m_st = 0; m_act = 0; m_f = 0;
        end else begin
          m_y = m_y - 1;
          if (m_anim == 7) begin m_anim = 0; m_f = (m_f + 1) % 3; end
          else m_anim = m_anim + 1;
        end
      end
      2: begin
        if (m_hold == 29) m_st = 3;
        else m_hold = m_hold + 1;
      end
      3: begin
        if (m_y + 4 >= 480) begin m_y = 480; m_st = 0; m_act = 0; m_f = 0; end
        else m_y = m_y + 4;
      end
      default: ;
    endcase
  endtask

  task automatic model_hit();
    if (m_st == 1) begin m_st = 2; m_f = 3; m_hold = 0; end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; vsync = 1'b0; start = 1'b0; hit = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic do_start(input int x, input bit dir);
    @(negedge clk);
    start = 1'b1; start_x = 12'(x); start_dir = dir;
    @(negedge clk);
    start = 1'b0;
    if (m_st == 0) begin
      m_st = 1; m_x = x; m_y = 480; m_inv = int'(dir); m_f = 0; m_anim = 0; m_act = 1;
    end
  endtask

  task automatic do_hit();
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    model_hit();
  endtask

  // One vsync rising edge; optionally with a hit on the very tick cycle
  task automatic frame_tick(input bit with_hit);
    @(negedge clk);
    vsync = 1'b1; hit = with_hit;
    @(negedge clk);
    hit = 1'b0;
    if (with_hit) model_hit();
    else model_tick();
    exp_q.push_back(snap());
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset(3);
    e = mk(0, 480, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL reset_init got=%h exp=%h", obs(), e); end
    do_start(100, 1'b0);
    repeat (5) begin
      frame_tick(1'b0);
      e = exp_q.pop_front();
    end
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL reset_preflight active got=%b exp=1", active); end
    do_reset(3);
    e = mk(0, 480, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL reset_midflight got=%h exp=%h", obs(), e); end
    total++;
    if (esc_seen != 0 || land_seen != 0) begin
      bad++; $display("FAIL reset_pulses got esc=%0d land=%0d exp 0/0", esc_seen, land_seen);
    end
  endtask

  task automatic test_launch();
    exp_t e;
    do_reset(2);
    do_start(100, 1'b0);
    e = mk(100, 480, 0, 0, 1);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL launch_start got=%h exp=%h", obs(), e); end
    for (int i = 0; i < 10; i++) begin
      frame_tick(1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL launch_tick%0d got=%h exp=%h", i, obs(), e); end
    end
    e = mk(120, 470, 1, 0, 1);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL launch_10 got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_bounce();
    exp_t e;
    do_reset(2);
    do_start(734, 1'b0);
    frame_tick(1'b0);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e) begin bad++; $display("FAIL bounce_model1 got=%h exp=%h", obs(), e); end
    total++;
    if (xpos !== 12'd736 || invert !== 1'b1) begin
      bad++; $display("FAIL bounce_edge got x=%0d inv=%b exp x=736 inv=1", xpos, invert);
    end
    frame_tick(1'b0);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e) begin bad++; $display("FAIL bounce_model2 got=%h exp=%h", obs(), e); end
    total++;
    if (xpos !== 12'd734 || invert !== 1'b1) begin
      bad++; $display("FAIL bounce_back got x=%0d inv=%b exp x=734 inv=1", xpos, invert);
    end
  endtask

  // Continues the flight left over from the bounce test up to the top edge
  task automatic test_escape();
    exp_t e;
    int e0;
    e0 = esc_seen;
    for (int i = 0; i < 600 && m_st == 1; i++) begin
      frame_tick(1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL escape_tick%0d got=%h exp=%h", i, obs(), e); end
    end
    total++;
    if (ypos !== 12'd0 || active !== 1'b0 || frame_sel !== 2'd0) begin
      bad++; $display("FAIL escape_final got y=%0d act=%b f=%0d exp y=0 act=0 f=0", ypos, active, frame_sel);
    end
    total++;
    if (esc_seen != e0 + 1) begin
      bad++; $display("FAIL escape_pulse got=%0d exp=%0d", esc_seen - e0, 1);
    end
    do_start(50, 1'b0);
    e = mk(50, 480, 0, 0, 1);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL escape_restart got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_hit_fall();
    exp_t e;
    int l0;
    do_reset(2);
    do_start(560, 1'b1);
    for (int i = 0; i < 180; i++) begin
      frame_tick(1'b0);
      e = exp_q.pop_front();
      if (i % 30 == 29) begin
        total++;
        if (obs() !== e) begin bad++; $display("FAIL approach_tick%0d got=%h exp=%h", i, obs(), e); end
      end
    end
    total++;
    if (xpos !== 12'd200 || ypos !== 12'd300) begin
      bad++; $display("FAIL hit_pos got x=%0d y=%0d exp x=200 y=300", xpos, ypos);
    end
    frame_tick(1'b1);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e) begin bad++; $display("FAIL hit_on_tick got=%h exp=%h", obs(), e); end
    e = mk(200, 300, 3, 1, 1);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL hit_pose got=%h exp=%h", obs(), e); end
    do_start(5, 1'b0);
    total++;
    if (xpos !== 12'd200 || frame_sel !== 2'd3 || active !== 1'b1) begin
      bad++; $display("FAIL start_in_hit got x=%0d f=%0d act=%b exp x=200 f=3 act=1", xpos, frame_sel, active);
    end
    for (int i = 0; i < 30; i++) begin
      frame_tick(1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL hold_tick%0d got=%h exp=%h", i, obs(), e); end
    end
    l0 = land_seen;
    for (int i = 0; i < 60 && m_st == 3; i++) begin
      frame_tick(1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL fall_tick%0d got=%h exp=%h", i, obs(), e); end
      if (i == 0) begin
        total++;
        if (ypos !== 12'd304) begin bad++; $display("FAIL fall_first got y=%0d exp y=304", ypos); end
      end
      if (i == 4) do_hit();
    end
    e = mk(200, 480, 0, 1, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL landed_state got=%h exp=%h", obs(), e); end
    total++;
    if (land_seen != l0 + 1) begin bad++; $display("FAIL landed_pulse got=%0d exp=1", land_seen - l0); end
    do_hit();
    total++;
    if (active !== 1'b0 || frame_sel !== 2'd0) begin
      bad++; $display("FAIL hit_in_idle got act=%b f=%0d exp act=0 f=0", active, frame_sel);
    end
  endtask

  task automatic test_vsync_hold();
    exp_t e;
    do_reset(2);
    do_start(300, 1'b0);
    @(negedge clk);
    vsync = 1'b1;
    repeat (100) @(negedge clk);
    vsync = 1'b0;
    model_tick();
    exp_q.push_back(snap());
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (obs() !== e) begin bad++; $display("FAIL vsync_hold_model got=%h exp=%h", obs(), e); end
    total++;
    if (xpos !== 12'd302 || ypos !== 12'd479) begin
      bad++; $display("FAIL vsync_hold got x=%0d y=%0d exp x=302 y=479", xpos, ypos);
    end
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b0; start = 1'b0; start_x = '0; start_dir = 1'b0; hit = 1'b0;
    model_reset();
    test_reset();
    test_launch();
    test_bounce();
    test_escape();
    test_hit_fall();
    test_vsync_hold();
    total++;
    if (both_seen != 0) begin bad++; $display("FAIL pulse_exclusive got=%0d exp=0", both_seen); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL queue_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
